dmem_access_ctrl: RTL and testbench

- Memory-stage data-memory access controller in the 5-stage RV32I pipeline.
- Sits directly downstream of the store-data formatter and upstream of the load-data extender.
- Converts a load/store request (address, funct3, low-lane store data) into a word-aligned data-memory bus transaction with byte enables and lane shifting.
- Runs the req/gnt/rvalid handshake, stalls the pipeline while the access is outstanding, and returns read data right-aligned to bit 0 for sign/zero extension.

---
 rtl/dmem_access_ctrl.sv | 153 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Memory-stage data-memory access controller: turns a load/store into an aligned bus
// transaction with byte enables, runs req/gnt/rvalid, and stalls the pipeline meanwhile.
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic             we_q;
  logic [29:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata_q;
  logic             misalign_q, err_q;

  logic       single, both, legal, misaligned, accept, timeout_hit;
  logic [3:0] be_new;

  assign single = mem_read_i ^ mem_write_i;
  assign both   = mem_read_i & mem_write_i;

  // Unsigned loads exist only for reads; stores accept b/h/w only.
  always_comb begin
    legal = 1'b0;
    case (funct3_i)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = mem_read_i;
      default:                legal = 1'b0;
    endcase
  end

  assign misaligned = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                      ((funct3_i[1:0] == 2'b10) & (|addr_i[1:0]));

  always_comb begin
    be_new = 4'b1111;
    case (funct3_i[1:0])
      2'b00:   be_new = 4'b0001 << addr_i[1:0];
      2'b01:   be_new = 4'b0011 << {addr_i[1], 1'b0};
      default: be_new = 4'b1111;
    endcase
  end

  assign accept = (state_q == StIdle) & single & legal & ~misaligned;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((state_q == StReq) || (state_q == StWait)) &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    state_d       = state_q;
    stall_o       = 1'b0;
    dmem_req_o    = 1'b0;
    rdata_valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          stall_o = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        if (timeout_hit) begin
          state_d = StIdle;
        end else begin
          stall_o    = 1'b1;
          dmem_req_o = 1'b1;
          // A same-cycle rvalid is ignored here; read data must arrive in StWait.
          if (dmem_gnt_i) state_d = we_q ? StDone : StWait;
        end
      end
      StWait: begin
        if (timeout_hit) begin
          state_d = StIdle;
        end else begin
          stall_o = 1'b1;
          if (dmem_rvalid_i) state_d = StDone;
        end
      end
      StDone: begin
        rdata_valid_o = ~we_q;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      off_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_q <= (state_q == StIdle) & single & legal & misaligned;
      err_q      <= (state_q == StIdle) & (both | (single & ~legal));
      cnt_q      <= ((state_q == StReq) || (state_q == StWait)) ? cnt_q + CNT_W'(1) : '0;
      if (accept) begin
        we_q    <= mem_write_i;
        addr_q  <= addr_i[31:2];
        be_q    <= be_new;
        wdata_q <= wdata_i << {addr_i[1:0], 3'b000};
        off_q   <= addr_i[1:0];
      end
      if (timeout_hit) begin
        rdata_q <= '0;
      end else if ((state_q == StWait) && dmem_rvalid_i) begin
        rdata_q <= dmem_rdata_i >> {off_q, 3'b000};
      end
    end
  end

  assign rdata_o      = rdata_q;
  assign misalign_o   = misalign_q;
  assign err_o        = err_q | timeout_hit;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q, 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-level reference model checked every cycle,
// directed literal checks from the plan, then randomized requests and bus responses.
module tb_dmem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 0, wr = 0;
  logic [2:0]  f3 = '0;
  logic [31:0] a = '0, wd = '0;
  logic        g = 0, rv = 0;
  logic [31:0] rdat = '0;

  logic        stall, rvalid_o, mis, err, req, we;
  logic [31:0] rdata, maddr, mwdata;
  logic [3:0]  be;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_i(rd), .mem_write_i(wr), .funct3_i(f3),
    .addr_i(a), .wdata_i(wd), .stall_o(stall), .rdata_o(rdata), .rdata_valid_o(rvalid_o),
    .misalign_o(mis), .err_o(err), .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(maddr),
    .dmem_be_o(be), .dmem_wdata_o(mwdata), .dmem_gnt_i(g), .dmem_rvalid_i(rv),
    .dmem_rdata_i(rdat)
  );

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction described by flags and counters.
  bit          m_busy, m_granted, m_done, m_done_rd, m_we, m_err_p, m_mis_p;
  int          m_elapsed;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic [1:0]  m_off;

  function automatic bit is_legal(input logic r, input logic [2:0] f);
    if (r) return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    return f <= 3'd2;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_granted = 0; m_done = 0; m_done_rd = 0; m_we = 0;
    m_err_p = 0; m_mis_p = 0; m_elapsed = 0; m_rdata = '0;
  endtask

  task automatic model_step();
    bit single, legal, aligned, acc, to, e_stall, e_req, e_valid, n_err, n_mis;
    int sz;
    single  = rd ^ wr;
    legal   = is_legal(rd, f3);
    sz      = 1 << f3[1:0];
    aligned = (int'(a[1:0]) % sz) == 0;
    acc     = !m_busy && !m_done && single && legal && aligned;
    to      = m_busy && (TO != 0) && (m_elapsed == TO);
    e_valid = 0;
    if (m_done) begin
      e_stall = 0; e_req = 0; e_valid = m_done_rd;
    end else if (m_busy) begin
      e_stall = !to; e_req = !to && !m_granted;
    end else begin
      e_stall = acc; e_req = 0;
    end
    chk("stall_o", 32'(stall), 32'(e_stall));
    chk("dmem_req_o", 32'(req), 32'(e_req));
    chk("rdata_valid_o", 32'(rvalid_o), 32'(e_valid));
    chk("err_o", 32'(err), 32'(m_err_p | to));
    chk("misalign_o", 32'(mis), 32'(m_mis_p));
    chk("rdata_o", rdata, m_rdata);
    if (e_req) begin
      chk("dmem_addr_o", maddr, m_addr);
      chk("dmem_be_o", 32'(be), 32'(m_be));
      chk("dmem_we_o", 32'(we), 32'(m_we));
      chk("dmem_wdata_o", mwdata, m_wdata);
    end
    n_err = 0; n_mis = 0;
    if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (to) begin
        m_busy = 0; m_rdata = '0;
      end else begin
        m_elapsed++;
        if (!m_granted) begin
          if (g) begin
            if (m_we) begin m_busy = 0; m_done = 1; m_done_rd = 0; end
            else m_granted = 1;
          end
        end else if (rv) begin
          m_rdata = rdat >> (8 * int'(m_off));
          m_busy = 0; m_done = 1; m_done_rd = 1;
        end
      end
    end else begin
      if (rd && wr) n_err = 1;
      else if (single && !legal) n_err = 1;
      else if (single && !aligned) n_mis = 1;
      else if (acc) begin
        m_busy = 1; m_granted = 0; m_elapsed = 0; m_we = wr;
        m_addr = a & 32'hFFFF_FFFC; m_off = a[1:0];
        m_be = 4'((((1 << sz) - 1) << (int'(a[1:0]) & ~(sz - 1))) & 15);
        m_wdata = wd << (8 * int'(a[1:0]));
      end
    end
    m_err_p = n_err; m_mis_p = n_mis;
  endtask

  task automatic cycle(input logic r, input logic w, input logic [2:0] f, input logic [31:0] ad,
                       input logic [31:0] wdat, input logic gn, input logic rvl,
                       input logic [31:0] rd_data);
    @(posedge clk);
    #1;
    rd = r; wr = w; f3 = f; a = ad; wd = wdat; g = gn; rv = rvl; rdat = rd_data;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle_cycle(input logic gn, input logic rvl, input logic [31:0] rd_data);
    cycle(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, gn, rvl, rd_data);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rd = 0; wr = 0; g = 0; rv = 0;
    rst_n = 1'b0;
    #1;
    chk("rst stall_o", 32'(stall), 32'h0);
    chk("rst dmem_req_o", 32'(req), 32'h0);
    chk("rst rdata_valid_o", 32'(rvalid_o), 32'h0);
    chk("rst err_o", 32'(err), 32'h0);
    chk("rst misalign_o", 32'(mis), 32'h0);
    chk("rst rdata_o", rdata, 32'h0);
    chk("rst dmem_be_o", 32'(be), 32'h0);
    chk("rst dmem_addr_o", maddr, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rnd_cycle();
    int r;
    logic rr, ww, gn, rvl;
    logic [2:0] f;
    logic [31:0] ad;
    r = $urandom_range(0, 9);
    rr = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : r[0];
    ww = (r == 0) ? 1'b1 : (r == 1) ? 1'b0 : ~r[0];
    if ($urandom_range(0, 9) < 7) begin
      case ($urandom_range(0, 4))
        0: f = 3'b000;
        1: f = 3'b001;
        2: f = 3'b010;
        3: f = 3'b100;
        default: f = 3'b101;
      endcase
    end else begin
      f = 3'($urandom);
    end
    ad = $urandom;
    if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
    gn  = $urandom_range(0, 99) < 45;
    rvl = $urandom_range(0, 99) < 45;
    cycle(rr, ww, f, ad, $urandom, gn, rvl, $urandom);
  endtask

  initial begin
    model_reset();
    apply_reset();

    // lw 0x100: accept, gnt, rvalid, done -> three stall cycles
    cycle(1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'h0);
    chk("lw accept stall", 32'(stall), 32'h1);
    idle_cycle(1, 0, 32'h0);
    chk("lw req", 32'(req), 32'h1);
    chk("lw be", 32'(be), 32'hF);
    chk("lw addr", maddr, 32'h100);
    chk("lw req stall", 32'(stall), 32'h1);
    idle_cycle(0, 1, 32'hDEADBEEF);
    chk("lw wait stall", 32'(stall), 32'h1);
    idle_cycle(0, 0, 32'h0);
    chk("lw done stall", 32'(stall), 32'h0);
    chk("lw valid", 32'(rvalid_o), 32'h1);
    chk("lw rdata", rdata, 32'hDEADBEEF);

    // sb 0x203
    cycle(0, 1, 3'b000, 32'h203, 32'h0000_00A5, 0, 0, 32'h0);
    chk("sb accept stall", 32'(stall), 32'h1);
    idle_cycle(1, 0, 32'h0);
    chk("sb addr", maddr, 32'h200);
    chk("sb be", 32'(be), 32'h8);
    chk("sb wdata", mwdata, 32'hA500_0000);
    chk("sb we", 32'(we), 32'h1);
    idle_cycle(0, 0, 32'h0);
    chk("sb done stall", 32'(stall), 32'h0);
    chk("sb no valid", 32'(rvalid_o), 32'h0);

    // lh 0x302
    cycle(1, 0, 3'b001, 32'h302, 32'h0, 0, 0, 32'h0);
    idle_cycle(1, 1, 32'h1111_1111);
    chk("lh be", 32'(be), 32'hC);
    idle_cycle(0, 1, 32'h8001_1234);
    idle_cycle(0, 0, 32'h0);
    chk("lh rdata", rdata, 32'h0000_8001);

    // misaligned lw, then illegal funct3 load
    cycle(1, 0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0);
    chk("mis stall", 32'(stall), 32'h0);
    idle_cycle(0, 0, 32'h0);
    chk("mis pulse", 32'(mis), 32'h1);
    chk("mis no err", 32'(err), 32'h0);
    chk("mis no req", 32'(req), 32'h0);
    cycle(1, 0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h0);
    idle_cycle(0, 0, 32'h0);
    chk("f3 err", 32'(err), 32'h1);
    chk("f3 no mis", 32'(mis), 32'h0);

    // timeout: gnt never arrives
    cycle(1, 0, 3'b010, 32'h40, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle_cycle(0, 0, 32'h0);
      chk("to req held", 32'(req), 32'h1);
    end
    idle_cycle(0, 0, 32'h0);
    chk("to err", 32'(err), 32'h1);
    chk("to stall", 32'(stall), 32'h0);
    chk("to req drop", 32'(req), 32'h0);
    idle_cycle(0, 0, 32'h0);
    chk("to err once", 32'(err), 32'h0);

    // reset during WAIT, then a late rvalid
    cycle(1, 0, 3'b010, 32'h80, 32'h0, 0, 0, 32'h0);
    idle_cycle(1, 0, 32'h0);
    apply_reset();
    idle_cycle(0, 1, 32'h1234_5678);
    idle_cycle(0, 0, 32'h0);
    chk("late rvalid ignored", 32'(rvalid_o), 32'h0);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      else rnd_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
